// File: rtl/axi_burst_write_engine_mo.sv
// Burst write engine: copies a block of words from a 1-cycle-latency local buffer
// to AXI memory as INCR bursts that never cross a 4 KB boundary, with up to
// MaxOutstanding bursts awaiting their write response.
module axi_burst_write_engine_mo #(
  parameter int unsigned BufferDataWidth = 32,
  parameter int unsigned BufferAddrWidth = 8,
  parameter int unsigned AXIAddrWidth    = 32,
  parameter int unsigned AXIDataWidth    = 32,
  parameter int unsigned AXIIDWidth      = 1,
  parameter int unsigned AXIID           = 0,
  parameter int unsigned AXIMaxBurstLen  = 16,
  parameter int unsigned MaxOutstanding  = 4
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        start_valid,
  output logic                        start_ready,
  input  logic [BufferAddrWidth-1:0]  data_ptr,
  input  logic [BufferAddrWidth:0]    data_size,
  input  logic [AXIAddrWidth-1:0]     axi_offset,
  output logic                        done_valid,
  input  logic                        done_ready,
  output logic                        done_error,
  output logic [BufferAddrWidth-1:0]  buffer_addr,
  output logic                        buffer_ce,
  output logic                        buffer_we,
  input  logic [BufferDataWidth-1:0]  buffer_data,
  output logic [AXIAddrWidth-1:0]     awaddr,
  output logic [7:0]                  awlen,
  output logic [2:0]                  awsize,
  output logic [1:0]                  awburst,
  output logic [AXIIDWidth-1:0]       awid,
  output logic                        awvalid,
  input  logic                        awready,
  output logic [AXIDataWidth-1:0]     wdata,
  output logic [AXIDataWidth/8-1:0]   wstrb,
  output logic [AXIIDWidth-1:0]       wid,
  output logic                        wlast,
  output logic                        wvalid,
  input  logic                        wready,
  input  logic [AXIIDWidth-1:0]       bid,
  input  logic [1:0]                  bresp,
  input  logic                        bvalid,
  output logic                        bready
);

  localparam int unsigned ByteShift = $clog2(AXIDataWidth / 8);
  localparam int unsigned LenW      = $clog2(AXIMaxBurstLen) + 1;
  localparam int unsigned CntW      = BufferAddrWidth + 1;
  localparam int unsigned CalcW     = (CntW > 13) ? CntW : 13;
  localparam int unsigned OutW      = $clog2(MaxOutstanding + 1);
  localparam int unsigned LfIdxW    = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam logic [AXIAddrWidth-1:0] AlignMask = ~AXIAddrWidth'((1 << ByteShift) - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t state, state_nxt;

  logic                       xfer_active;
  logic                       start_fire, aw_take, b_take, w_take;
  logic                       aw_present, aw_room;
  logic [AXIAddrWidth-1:0]    src_addr, cur_addr;
  logic [CalcW-1:0]           src_rem, to_bnd, burst_len;
  logic [CntW-1:0]            aw_remaining, rd_remaining, w_remaining;
  logic [BufferAddrWidth-1:0] rd_addr;
  logic [OutW-1:0]            outstanding, out_nxt;
  logic [LenW-1:0]            aw_len_q;
  logic                       err;

  logic [LenW-1:0]            lf_mem [MaxOutstanding];
  logic [LfIdxW-1:0]          lf_wr, lf_rd;
  logic [OutW-1:0]            lf_cnt, lf_cnt_nxt;
  logic                       lf_pop;
  logic [LenW-1:0]            w_beat;

  logic [BufferDataWidth-1:0] sk_mem [2];
  logic                       sk_wr, sk_rd;
  logic [1:0]                 sk_cnt;
  logic                       rd_inflight;
  logic                       unused_bid;

  assign unused_bid = ^bid;

  // Constant channel attributes.
  assign awsize      = 3'(ByteShift);
  assign awburst     = 2'b01;
  assign awid        = AXIIDWidth'(AXIID);
  assign wid         = AXIIDWidth'(AXIID);
  assign wstrb       = '1;
  assign buffer_we   = 1'b0;
  assign buffer_addr = rd_addr;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_valid) state_nxt = (data_size == '0) ? DONE : RUN;
      RUN:     if (aw_take && aw_remaining == '0) state_nxt = DRAIN;
      DRAIN:   if (w_remaining == '0 && outstanding == '0) state_nxt = DONE;
      DONE:    if (done_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    start_ready = 1'b0;
    done_valid  = 1'b0;
    bready      = 1'b1;
    xfer_active = 1'b0;
    case (state)
      IDLE:    begin start_ready = 1'b1; bready = 1'b0; end
      RUN:     xfer_active = 1'b1;
      DRAIN:   xfer_active = 1'b1;
      DONE:    done_valid = 1'b1;
      default: bready = 1'b0;
    endcase
  end

  assign done_error = err;

  // Handshake events and next-burst length (limited by words left, max burst and 4 KB page).
  always_comb begin
    start_fire = start_valid && start_ready;
    aw_take    = awvalid && awready;
    b_take     = bvalid && bready;
    src_addr   = (state == IDLE) ? (axi_offset & AlignMask) : cur_addr;
    src_rem    = (state == IDLE) ? CalcW'(data_size) : CalcW'(aw_remaining);
    to_bnd     = CalcW'((13'h1000 - {1'b0, src_addr[11:0]}) >> ByteShift);
    burst_len  = CalcW'(AXIMaxBurstLen);
    if (src_rem < burst_len) burst_len = src_rem;
    if (to_bnd < burst_len)  burst_len = to_bnd;
    out_nxt    = outstanding + OutW'(aw_take) - OutW'(b_take);
    lf_cnt_nxt = lf_cnt + OutW'(aw_take) - OutW'(lf_pop);
    aw_room    = (out_nxt < OutW'(MaxOutstanding)) && (lf_cnt_nxt < OutW'(MaxOutstanding));
    aw_present = (!awvalid || aw_take) &&
                 ((start_fire && data_size != '0) ||
                  (state == RUN && aw_remaining != '0 && aw_room));
  end

  // AW channel: present a burst, hold it until accepted, chain the next one immediately.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      awvalid      <= 1'b0;
      awaddr       <= '0;
      awlen        <= '0;
      aw_len_q     <= '0;
      cur_addr     <= '0;
      aw_remaining <= '0;
    end else if (aw_present) begin
      awvalid      <= 1'b1;
      awaddr       <= src_addr;
      awlen        <= 8'(burst_len - CalcW'(1));
      aw_len_q     <= LenW'(burst_len);
      cur_addr     <= src_addr + (AXIAddrWidth'(burst_len) << ByteShift);
      aw_remaining <= CntW'(src_rem - burst_len);
    end else if (aw_take) begin
      awvalid <= 1'b0;
    end
  end

  // Count of accepted bursts still waiting for their write response.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) outstanding <= '0;
    else          outstanding <= out_nxt;
  end

  // Sticky response error, cleared by each new command.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                                          err <= 1'b0;
    else if (start_fire)                                   err <= 1'b0;
    else if (b_take && (bresp == 2'b10 || bresp == 2'b11)) err <= 1'b1;
  end

  // Length FIFO hands accepted burst lengths to the W side in AW order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lf_wr  <= '0;
      lf_rd  <= '0;
      lf_cnt <= '0;
      for (int i = 0; i < int'(MaxOutstanding); i++) lf_mem[i] <= '0;
    end else begin
      lf_cnt <= lf_cnt_nxt;
      if (aw_take) begin
        lf_mem[lf_wr] <= aw_len_q;
        lf_wr <= (lf_wr == LfIdxW'(MaxOutstanding - 1)) ? '0 : lf_wr + LfIdxW'(1);
      end
      if (lf_pop) lf_rd <= (lf_rd == LfIdxW'(MaxOutstanding - 1)) ? '0 : lf_rd + LfIdxW'(1);
    end
  end

  // W beat presentation: data comes from the skid FIFO once its burst's AW is accepted.
  always_comb begin
    wvalid = (sk_cnt != 2'd0) && (lf_cnt != '0);
    wdata  = AXIDataWidth'(sk_mem[sk_rd]);
    wlast  = (w_beat == LenW'(lf_mem[lf_rd] - LenW'(1)));
    w_take = wvalid && wready;
    lf_pop = w_take && wlast;
  end

  // Beat position inside the current W burst.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    w_beat <= '0;
    else if (lf_pop) w_beat <= '0;
    else if (w_take) w_beat <= w_beat + LenW'(1);
  end

  // Buffer read issue: keep skid entries plus the read in flight within two.
  always_comb begin
    buffer_ce = xfer_active && (rd_remaining != '0) &&
                (({1'b0, sk_cnt} + 3'(rd_inflight)) < (3'd2 + 3'(w_take)));
  end

  // Command latch, read address/count, and total beats left to send.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_addr      <= '0;
      rd_remaining <= '0;
      w_remaining  <= '0;
      rd_inflight  <= 1'b0;
    end else begin
      rd_inflight <= buffer_ce;
      if (start_fire) begin
        rd_addr      <= data_ptr;
        rd_remaining <= data_size;
        w_remaining  <= data_size;
      end else begin
        if (buffer_ce) begin
          rd_addr      <= rd_addr + BufferAddrWidth'(1);
          rd_remaining <= rd_remaining - CntW'(1);
        end
        if (w_take) w_remaining <= w_remaining - CntW'(1);
      end
    end
  end

  // Two-entry skid FIFO absorbing the read latency under wready backpressure.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sk_wr     <= 1'b0;
      sk_rd     <= 1'b0;
      sk_cnt    <= 2'd0;
      sk_mem[0] <= '0;
      sk_mem[1] <= '0;
    end else begin
      sk_cnt <= sk_cnt + 2'(rd_inflight) - 2'(w_take);
      if (rd_inflight) begin
        sk_mem[sk_wr] <= buffer_data;
        sk_wr <= ~sk_wr;
      end
      if (w_take) sk_rd <= ~sk_rd;
    end
  end

endmodule

// File: tb/tb_axi_burst_write_engine_mo.sv
// Bench for axi_burst_write_engine_mo: AXI slave BFM with scoreboarded AW/W traffic.
module tb_axi_burst_write_engine_mo;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start_valid, start_ready;
  logic [7:0]  data_ptr;
  logic [8:0]  data_size;
  logic [31:0] axi_offset;
  logic        done_valid, done_ready, done_error;
  logic [7:0]  buffer_addr;
  logic        buffer_ce, buffer_we;
  logic [31:0] buffer_data;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic [0:0]  awid, wid, bid;
  logic        awvalid, awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast, wvalid, wready;
  logic [1:0]  bresp;
  logic        bvalid, bready;

  always #5 clk = ~clk;

  axi_burst_write_engine_mo dut (
    .clk(clk), .reset_n(reset_n),
    .start_valid(start_valid), .start_ready(start_ready),
    .data_ptr(data_ptr), .data_size(data_size), .axi_offset(axi_offset),
    .done_valid(done_valid), .done_ready(done_ready), .done_error(done_error),
    .buffer_addr(buffer_addr), .buffer_ce(buffer_ce), .buffer_we(buffer_we),
    .buffer_data(buffer_data),
    .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awid(awid), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wid(wid), .wlast(wlast), .wvalid(wvalid),
    .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  logic [31:0] buf_mem [256];
  logic [39:0] aw_exp_q [$];
  logic [32:0] w_exp_q [$];
  int          b_time_q [$];
  logic [1:0]  b_resp_q [$];

  int errors = 0;
  int checks = 0;
  int cycle = 0;
  int unacked = 0, peak_unacked = 0;
  int b_delay = 0, aw_stall_pct = 0, w_stall_pct = 0;
  int err_burst = 0, burst_idx = 0;
  int aw_seen = 0, w_seen = 0;
  int w_stall_left = 0;
  logic        b_acc = 1'b0;
  logic        prev_w_hold = 1'b0;
  logic [31:0] prev_wdata = '0;
  logic [39:0] aw_e;
  logic [32:0] w_e;

  // Buffer model: one-cycle read latency.
  always @(posedge clk) if (buffer_ce) buffer_data <= buf_mem[buffer_addr];

  // AXI slave BFM: drives ready/B on the falling edge; a handshake seen here completes at the next rising edge.
  always @(negedge clk) begin
    cycle++;
    if (!reset_n) begin
      awready = 1'b0; wready = 1'b0; bvalid = 1'b0; b_acc = 1'b0; prev_w_hold = 1'b0;
    end else begin
      if (b_acc) begin bvalid = 1'b0; unacked--; end
      awready = ($urandom_range(99) >= aw_stall_pct);
      if (awvalid && awready) begin
        aw_seen++; unacked++;
        if (unacked > peak_unacked) peak_unacked = unacked;
        checks++;
        if (aw_exp_q.size() == 0) begin
          errors++; $display("FAIL aw_unexpected got addr=%h len=%0d", awaddr, awlen);
        end else begin
          aw_e = aw_exp_q.pop_front();
          if ({awaddr, awlen} !== aw_e)
            begin errors++; $display("FAIL aw_burst got addr=%h len=%0d expected addr=%h len=%0d",
                                      awaddr, awlen, aw_e[39:8], aw_e[7:0]); end
        end
      end
      if (prev_w_hold) begin
        checks++;
        if (wvalid !== 1'b1 || wdata !== prev_wdata)
          begin errors++; $display("FAIL w_stable got valid=%b data=%h expected valid=1 data=%h", wvalid, wdata, prev_wdata); end
      end
      if (w_stall_left > 0) begin wready = 1'b0; w_stall_left--; end
      else if ($urandom_range(99) < w_stall_pct) begin wready = 1'b0; w_stall_left = $urandom_range(4); end
      else wready = 1'b1;
      if (wvalid && wready) begin
        w_seen++; checks++;
        if (w_exp_q.size() == 0) begin
          errors++; $display("FAIL w_unexpected got data=%h last=%b", wdata, wlast);
        end else begin
          w_e = w_exp_q.pop_front();
          if ({wlast, wdata} !== w_e)
            begin errors++; $display("FAIL w_beat got last=%b data=%h expected last=%b data=%h", wlast, wdata, w_e[32], w_e[31:0]); end
          if (w_e[32]) begin
            burst_idx++;
            b_time_q.push_back(cycle + b_delay + 1);
            b_resp_q.push_back((burst_idx == err_burst) ? 2'b10 : 2'b00);
          end
        end
      end
      prev_w_hold = wvalid && !wready;
      prev_wdata  = wdata;
      if (!bvalid && b_time_q.size() > 0 && b_time_q[0] <= cycle) begin
        bvalid = 1'b1;
        bresp  = b_resp_q.pop_front();
        void'(b_time_q.pop_front());
      end
      b_acc = bvalid && bready;
    end
  end

  // Push expected bursts and beats for one command; returns whether an error response is expected.
  task automatic prep_cmd(input int ptr, input int size, input int off, input int ebur, output bit exp_err);
    int addr, rem, len, to4k, k, nb;
    addr = off & 32'hFFFF_FFFC; rem = size; k = 0; nb = 0;
    err_burst = ebur; burst_idx = 0; peak_unacked = unacked;
    while (rem > 0) begin
      to4k = (4096 - (addr % 4096)) / 4;
      len = (rem < 16) ? rem : 16;
      if (to4k < len) len = to4k;
      aw_exp_q.push_back({32'(addr), 8'(len - 1)});
      for (int j = 0; j < len; j++) begin
        w_exp_q.push_back({(j == len - 1), buf_mem[(ptr + k) % 256]});
        k++;
      end
      addr += len * 4; rem -= len; nb++;
    end
    exp_err = (ebur >= 1 && ebur <= nb);
  endtask

  task automatic do_start(input int ptr, input int size, input int off, input bit chk_lat);
    int t;
    @(negedge clk);
    start_valid = 1'b1; data_ptr = 8'(ptr); data_size = 9'(size); axi_offset = 32'(off);
    t = 0;
    while (!start_ready && t < 100) begin @(negedge clk); t++; end
    @(negedge clk);
    start_valid = 1'b0;
    if (chk_lat) begin
      checks++;
      if (awvalid !== 1'b1) begin errors++; $display("FAIL aw_latency got awvalid=%b expected 1", awvalid); end
    end
  endtask

  task automatic wait_done(input bit exp_err, input string tag);
    int t;
    t = 0;
    while (done_valid !== 1'b1 && t < 20000) begin @(negedge clk); t++; end
    checks++;
    if (done_valid !== 1'b1) begin
      errors++; $display("FAIL %s_timeout got done_valid=%b expected 1", tag, done_valid);
    end else begin
      checks++;
      if (done_error !== exp_err) begin errors++; $display("FAIL %s_done_error got %b expected %b", tag, done_error, exp_err); end
      done_ready = 1'b1;
      @(negedge clk);
      done_ready = 1'b0;
      checks++;
      if (start_ready !== 1'b1) begin errors++; $display("FAIL %s_back_idle got start_ready=%b expected 1", tag, start_ready); end
    end
    checks++;
    if (aw_exp_q.size() != 0 || w_exp_q.size() != 0)
      begin errors++; $display("FAIL %s_leftover got aw=%0d w=%0d pending expected 0", tag, aw_exp_q.size(), w_exp_q.size()); end
    aw_exp_q.delete(); w_exp_q.delete();
  endtask

  task automatic run_cmd(input int ptr, input int size, input int off, input int ebur, input bit chk_lat, input string tag);
    bit e;
    prep_cmd(ptr, size, off, ebur, e);
    do_start(ptr, size, off, chk_lat);
    wait_done(e, tag);
  endtask

  task automatic test_reset();
    checks++;
    if (awvalid !== 1'b0 || wvalid !== 1'b0 || buffer_ce !== 1'b0 || done_valid !== 1'b0 || bready !== 1'b0)
      begin errors++; $display("FAIL reset_outputs got aw=%b w=%b ce=%b done=%b bready=%b expected all 0",
                                awvalid, wvalid, buffer_ce, done_valid, bready); end
    checks++;
    if (awsize !== 3'd2 || awburst !== 2'b01 || wstrb !== 4'hF || buffer_we !== 1'b0 || awid !== 1'b0 || wid !== 1'b0)
      begin errors++; $display("FAIL static_outputs got size=%0d burst=%0d strb=%h we=%b", awsize, awburst, wstrb, buffer_we); end
    @(negedge clk); #2 reset_n = 1'b1;
    @(negedge clk);
    checks++;
    if (start_ready !== 1'b1) begin errors++; $display("FAIL reset_start_ready got %b expected 1", start_ready); end
  endtask

  task automatic test_single();
    run_cmd(0, 1, 32'h0, 0, 1'b1, "single");
  endtask

  task automatic test_multi_burst();
    run_cmd(16, 40, 32'h100, 0, 1'b1, "multi");
  endtask

  task automatic test_4k_boundary();
    run_cmd(3, 10, 32'hFF8, 0, 1'b0, "cross4k");
  endtask

  task automatic test_outstanding();
    b_delay = 50;
    run_cmd(200, 128, 32'h2000, 0, 1'b0, "outstanding");
    checks++;
    if (peak_unacked != 4) begin errors++; $display("FAIL max_outstanding got %0d expected 4", peak_unacked); end
    b_delay = 0;
  endtask

  task automatic test_backpressure();
    w_stall_pct = 50; aw_stall_pct = 30;
    run_cmd(100, 100, 32'h3F04, 0, 1'b0, "stall");
    run_cmd(250, 37, 32'h5FFC, 0, 1'b0, "stall_wrap");
    w_stall_pct = 0; aw_stall_pct = 0;
  endtask

  task automatic test_slverr();
    run_cmd(5, 40, 32'h800, 2, 1'b0, "slverr");
    run_cmd(9, 5, 32'h40, 0, 1'b0, "err_cleared");
  endtask

  task automatic test_size_zero();
    int a0, w0;
    a0 = aw_seen; w0 = w_seen;
    run_cmd(0, 0, 32'h0, 0, 1'b0, "size0");
    checks++;
    if (aw_seen != a0 || w_seen != w0)
      begin errors++; $display("FAIL size0_traffic got aw=%0d w=%0d expected 0 0", aw_seen - a0, w_seen - w0); end
  endtask

  task automatic test_reset_mid();
    bit e;
    prep_cmd(0, 128, 32'h1000, 0, e);
    do_start(0, 128, 32'h1000, 1'b0);
    repeat (15) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (awvalid !== 1'b0 || wvalid !== 1'b0 || buffer_ce !== 1'b0 || done_valid !== 1'b0)
      begin errors++; $display("FAIL mid_reset got aw=%b w=%b ce=%b done=%b expected all 0", awvalid, wvalid, buffer_ce, done_valid); end
    aw_exp_q.delete(); w_exp_q.delete(); b_time_q.delete(); b_resp_q.delete();
    unacked = 0; w_stall_left = 0; bvalid = 1'b0; b_acc = 1'b0; prev_w_hold = 1'b0;
    repeat (2) @(negedge clk);
    #2 reset_n = 1'b1;
    run_cmd(60, 20, 32'h700, 0, 1'b1, "after_reset");
  endtask

  initial begin
    for (int i = 0; i < 256; i++) buf_mem[i] = $urandom();
    reset_n = 1'b0; start_valid = 1'b0; done_ready = 1'b0;
    data_ptr = '0; data_size = '0; axi_offset = '0;
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00; bid = 1'b0;
    buffer_data = '0;
    repeat (3) @(negedge clk);
    #1;
    test_reset();
    test_single();
    test_multi_burst();
    test_4k_boundary();
    test_outstanding();
    test_backpressure();
    test_slverr();
    test_size_zero();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
